// File: rtl/branch1_pkg.sv
// Shared types and constants for the branch-metric frame scheduler.
// Holds the scheduler state encoding, sweep direction codes and the
// address-width helper used to size store addresses from the store depth.
package branch1_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_DISCARD,
    ST_DRAIN,
    ST_FWD,
    ST_BWD
  } state_t;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_BWD = 1'b1;

  localparam int DEF_BRANCH_SIZE = 3072;

  // Address width for a store of the given depth (never narrower than 1 bit).
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int DEF_AW = addr_width(DEF_BRANCH_SIZE);

endpackage

// File: rtl/branch1_rd_sequencer.sv
// Read-address sequencer for the forward and backward sweeps over a stored frame.
// Ports: clk/rst; i_clr zeroes the counter, i_issue issues o_addr this cycle in
// direction i_dir over a frame of i_len items; o_at_end flags the sweep's final
// address; o_rd_* are the registered qualifiers of the read issued last cycle.
module branch1_rd_sequencer
  import branch1_pkg::*;
#(
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_issue,
  input  logic          i_dir,
  input  logic [AW:0]   i_len,
  output logic [AW-1:0] o_addr,
  output logic          o_at_end,
  output logic          o_rd_valid,
  output logic          o_rd_dir,
  output logic          o_rd_first,
  output logic          o_rd_last
);

  logic [AW-1:0] r_cnt;
  logic          r_rd_valid;
  logic          r_rd_dir;
  logic          r_rd_first;
  logic          r_rd_last;
  logic          w_at_zero;
  logic          w_at_top;

  assign w_at_zero = (r_cnt == '0);
  assign w_at_top  = ({1'b0, r_cnt} == (i_len - (AW+1)'(1)));
  assign o_at_end  = (i_dir == DIR_FWD) ? w_at_top : w_at_zero;

  assign o_addr     = r_cnt;
  assign o_rd_valid = r_rd_valid;
  assign o_rd_dir   = r_rd_dir;
  assign o_rd_first = r_rd_first;
  assign o_rd_last  = r_rd_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_dir   <= 1'b0;
      r_rd_first <= 1'b0;
      r_rd_last  <= 1'b0;
    end else begin
      r_rd_valid <= i_issue;
      r_rd_dir   <= i_issue & i_dir;
      r_rd_first <= i_issue & ((i_dir == DIR_FWD) ? w_at_zero : w_at_top);
      r_rd_last  <= i_issue & ((i_dir == DIR_FWD) ? w_at_top : w_at_zero);
      // At the end of a sweep the counter holds: the top address is exactly
      // where the backward sweep starts, so the turn-around has no bubble.
      if (i_clr) begin
        r_cnt <= '0;
      end else if (i_issue && !o_at_end) begin
        r_cnt <= (i_dir == DIR_FWD) ? r_cnt + AW'(1) : r_cnt - AW'(1);
      end
    end
  end

endmodule

// File: rtl/branch1_scheduler.sv
// Sequences one frame through the branch-metric store: fill writes, drain, then forward/backward read sweeps.
// Ports: s_* input beat stream (s_ready registered); bm_* write port and bm_rd_addr read address of the store;
// rd_ready/rd_* read handshake toward the recursion units; frame_len, busy, err_overflow status.
module branch1_scheduler
  import branch1_pkg::*;
#(
  parameter  int DWIDTH       = 16,
  parameter  int BRANCH_SIZE  = DEF_BRANCH_SIZE,
  parameter  int CALC_LATENCY = 2,
  localparam int AW           = addr_width(BRANCH_SIZE)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [DWIDTH-1:0] s_sys,
  input  logic [DWIDTH-1:0] s_parity,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [DWIDTH-1:0] bm_sys_item,
  output logic [DWIDTH-1:0] bm_parity_item,
  output logic [AW-1:0]     bm_addr,
  output logic              bm_valid,
  output logic [AW-1:0]     bm_rd_addr,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic              rd_dir,
  output logic              rd_first,
  output logic              rd_last,
  output logic [AW:0]       frame_len,
  output logic              busy,
  output logic              err_overflow
);

  localparam int DCW = $clog2(CALC_LATENCY + 2);
  localparam logic [DCW-1:0] DRAIN_DONE = DCW'(CALC_LATENCY + 1);

  state_t            r_state;
  state_t            w_next;
  logic              r_s_ready;
  logic [DWIDTH-1:0] r_bm_sys;
  logic [DWIDTH-1:0] r_bm_par;
  logic [AW-1:0]     r_bm_addr;
  logic              r_bm_valid;
  logic [AW-1:0]     r_wr_cnt;
  logic [AW:0]       r_frame_len;
  logic              r_err;
  logic [DCW-1:0]    r_drain_cnt;

  logic          w_accept;
  logic          w_write;
  logic          w_overflow;
  logic          w_clr;
  logic          w_issue;
  logic          w_dir;
  logic          w_at_end;
  logic [AW-1:0] w_wr_addr;

  assign w_accept  = s_valid & r_s_ready;
  // A new frame always starts at address 0, whatever wr_cnt was left at.
  assign w_wr_addr = (r_state == ST_IDLE) ? '0 : r_wr_cnt;

  assign s_ready        = r_s_ready;
  assign bm_sys_item    = r_bm_sys;
  assign bm_parity_item = r_bm_par;
  assign bm_addr        = r_bm_addr;
  assign bm_valid       = r_bm_valid;
  assign frame_len      = r_frame_len;
  assign err_overflow   = r_err;
  assign busy           = (r_state != ST_IDLE);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_write    = 1'b0;
    w_overflow = 1'b0;
    w_clr      = 1'b0;
    w_issue    = 1'b0;
    w_dir      = DIR_FWD;
    case (r_state)
      ST_IDLE, ST_FILL: begin
        if (w_accept) begin
          w_write = 1'b1;
          if (s_last) begin
            w_next = ST_DRAIN;
          end else if (w_wr_addr == AW'(BRANCH_SIZE - 1)) begin
            w_overflow = 1'b1;
            w_next     = ST_DISCARD;
          end else begin
            w_next = ST_FILL;
          end
        end
      end
      ST_DISCARD: begin
        if (w_accept && s_last) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_clr = 1'b1;
        if (!r_bm_valid && (r_drain_cnt == DRAIN_DONE)) w_next = ST_FWD;
      end
      ST_FWD: begin
        w_issue = rd_ready;
        if (rd_ready && w_at_end) w_next = ST_BWD;
      end
      ST_BWD: begin
        w_dir   = DIR_BWD;
        w_issue = rd_ready;
        if (rd_ready && w_at_end) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_s_ready   <= 1'b0;
      r_bm_sys    <= '0;
      r_bm_par    <= '0;
      r_bm_addr   <= '0;
      r_bm_valid  <= 1'b0;
      r_wr_cnt    <= '0;
      r_frame_len <= '0;
      r_err       <= 1'b0;
      r_drain_cnt <= '0;
    end else begin
      r_s_ready  <= (w_next == ST_IDLE) || (w_next == ST_FILL) || (w_next == ST_DISCARD);
      r_bm_valid <= w_write;
      if (w_write) begin
        r_bm_sys  <= s_sys;
        r_bm_par  <= s_parity;
        r_bm_addr <= w_wr_addr;
        r_wr_cnt  <= w_wr_addr + AW'(1);
      end
      if (w_write && s_last) r_frame_len <= {1'b0, w_wr_addr} + (AW+1)'(1);
      else if (w_overflow)   r_frame_len <= (AW+1)'(BRANCH_SIZE);
      if ((r_state == ST_IDLE) && w_accept) r_err <= 1'b0;
      else if (w_overflow)                  r_err <= 1'b1;
      // Counts idle cycles since the last store write; saturates at the
      // point where the calc pipeline is known to be empty.
      if (r_bm_valid)                      r_drain_cnt <= DCW'(1);
      else if (r_drain_cnt != DRAIN_DONE)  r_drain_cnt <= r_drain_cnt + DCW'(1);
    end
  end

  branch1_rd_sequencer #(
    .AW(AW)
  ) u_rd_seq (
    .clk       (aclk),
    .rst       (areset),
    .i_clr     (w_clr),
    .i_issue   (w_issue),
    .i_dir     (w_dir),
    .i_len     (r_frame_len),
    .o_addr    (bm_rd_addr),
    .o_at_end  (w_at_end),
    .o_rd_valid(rd_valid),
    .o_rd_dir  (rd_dir),
    .o_rd_first(rd_first),
    .o_rd_last (rd_last)
  );

endmodule

// File: tb/tb_branch1_scheduler.sv
// Bench for branch1_scheduler with an 8-deep store and calc latency 2.
// Random beats and gaps are driven per frame; a frame-level model predicts
// the write list, read order/flags and the issue timing from rd_ready history.
module tb_branch1_scheduler;

  localparam int DW   = 16;
  localparam int BS   = 8;
  localparam int CL   = 2;
  localparam int AW   = 3;
  localparam int HIST = 20000;

  typedef struct {
    int         addr;
    logic [15:0] sys;
    logic [15:0] par;
    int         cyc;
  } wr_t;

  typedef struct {
    int   addr;
    logic dir;
    logic first;
    logic last;
    logic busy;
    int   cyc;
  } rd_t;

  logic          aclk;
  logic          areset;
  logic [DW-1:0] s_sys;
  logic [DW-1:0] s_parity;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic [DW-1:0] bm_sys_item;
  logic [DW-1:0] bm_parity_item;
  logic [AW-1:0] bm_addr;
  logic          bm_valid;
  logic [AW-1:0] bm_rd_addr;
  logic          rd_ready;
  logic          rd_valid;
  logic          rd_dir;
  logic          rd_first;
  logic          rd_last;
  logic [AW:0]   frame_len;
  logic          busy;
  logic          err_overflow;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rd_mode = 0;
  int   last_acc = 0;
  logic rdy_hist [0:HIST-1];
  wr_t  wq[$];
  rd_t  rq[$];
  wr_t  exp_w[$];

  branch1_scheduler #(
    .DWIDTH(DW),
    .BRANCH_SIZE(BS),
    .CALC_LATENCY(CL)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_sys(s_sys), .s_parity(s_parity), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .bm_sys_item(bm_sys_item), .bm_parity_item(bm_parity_item), .bm_addr(bm_addr),
    .bm_valid(bm_valid), .bm_rd_addr(bm_rd_addr), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_dir(rd_dir), .rd_first(rd_first), .rd_last(rd_last),
    .frame_len(frame_len), .busy(busy), .err_overflow(err_overflow)
  );

  initial begin
    aclk = 0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    forever begin
      @(posedge aclk);
      cyc++;
    end
  end

  // rd_ready: mode 0 always ready, mode 1 repeating 1,0,0,1, mode 2 random.
  initial begin
    int pc;
    pc = 0;
    rd_ready = 0;
    forever begin
      @(posedge aclk);
      #1;
      case (rd_mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = ((pc % 4) == 0) || ((pc % 4) == 3);
        default: rd_ready = 1'($urandom_range(1));
      endcase
      pc++;
    end
  end

  // Monitor: a read delivered at cycle c belongs to the address presented at c-1.
  initial begin
    logic [AW-1:0] prev_addr;
    wr_t w;
    rd_t r;
    prev_addr = '0;
    forever begin
      @(negedge aclk);
      if (cyc < HIST) rdy_hist[cyc] = rd_ready;
      if (bm_valid === 1'b1) begin
        w.addr = int'(bm_addr); w.sys = bm_sys_item; w.par = bm_parity_item; w.cyc = cyc;
        wq.push_back(w);
      end
      if (rd_valid === 1'b1) begin
        r.addr = int'(prev_addr); r.dir = rd_dir; r.first = rd_first; r.last = rd_last;
        r.busy = busy; r.cyc = cyc;
        rq.push_back(r);
      end
      prev_addr = bm_rd_addr;
    end
  end

  initial begin
    #150000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_beats(input int n, input int gap);
    int  b;
    wr_t w;
    exp_w.delete();
    for (int i = 0; i < n; i++) begin
      while (gap > 0 && $urandom_range(99) < gap) begin
        s_valid = 0; s_last = 0;
        @(posedge aclk); #1;
      end
      s_valid = 1; s_sys = DW'($urandom); s_parity = DW'($urandom); s_last = (i == n - 1);
      b = 0;
      while (!s_ready && b < 50) begin
        @(posedge aclk); #1; b++;
      end
      chk("s_ready_wait", 32'(s_ready), 1);
      @(posedge aclk); #1;
      last_acc = cyc;
      if (i < BS) begin
        w.addr = i; w.sys = s_sys; w.par = s_parity; w.cyc = cyc;
        exp_w.push_back(w);
      end
      if (i == 0) chk("err_clr", 32'(err_overflow), 0);
    end
    s_valid = 0; s_last = 0;
  endtask

  task automatic check_frame(input int n);
    int L, start, c, ea;
    L = (n < BS) ? n : BS;
    for (int t = 0; t < 3000 && rq.size() < 2 * L; t++) @(posedge aclk);
    repeat (3) @(posedge aclk);
    #1;
    chk("wr_count", wq.size(), L);
    for (int i = 0; i < wq.size() && i < L; i++) begin
      chk("wr_addr", wq[i].addr, i);
      chk("wr_sys", 32'(wq[i].sys), 32'(exp_w[i].sys));
      chk("wr_par", 32'(wq[i].par), 32'(exp_w[i].par));
      chk("wr_cyc", wq[i].cyc, exp_w[i].cyc);
    end
    chk("frame_len", 32'(frame_len), L);
    chk("err_overflow", 32'(err_overflow), (n > BS) ? 1 : 0);
    chk("busy_idle", 32'(busy), 0);
    chk("s_ready_idle", 32'(s_ready), 1);
    chk("rd_count", rq.size(), 2 * L);
    for (int k = 0; k < rq.size() && k < 2 * L; k++) begin
      ea = (k < L) ? k : 2 * L - 1 - k;
      chk("rd_addr", rq[k].addr, ea);
      chk("rd_dir", 32'(rq[k].dir), (k >= L) ? 1 : 0);
      chk("rd_first", 32'(rq[k].first), (k == 0 || k == L) ? 1 : 0);
      chk("rd_last", 32'(rq[k].last), (k == L - 1 || k == 2 * L - 1) ? 1 : 0);
      chk("rd_busy", 32'(rq[k].busy), (k == 2 * L - 1) ? 0 : 1);
      // First issue: calc pipeline drained (CL+1 idle cycles after the last
      // write) and input closed; later issues: the next ready cycle.
      if (k == 0) begin
        start = exp_w[L-1].cyc + CL + 2;
        if (last_acc + 1 > start) start = last_acc + 1;
      end else begin
        start = rq[k-1].cyc;
      end
      c = start;
      while (c < HIST - 1 && rdy_hist[c] !== 1'b1) c++;
      chk("rd_cyc", rq[k].cyc, c + 1);
    end
  endtask

  task automatic run_frame(input int n, input int gap, input int mode);
    rd_mode = mode;
    wq.delete();
    rq.delete();
    send_beats(n, gap);
    check_frame(n);
  endtask

  initial begin
    areset = 1; s_sys = 0; s_parity = 0; s_valid = 0; s_last = 0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_ctrl", {24'd0, s_ready, bm_valid, rd_valid, rd_dir, rd_first, rd_last, busy, err_overflow}, 0);
    chk("rst_addr", {bm_addr, bm_rd_addr, frame_len}, 0);
    chk("rst_items", {bm_sys_item, bm_parity_item}, 0);
    areset = 0;

    run_frame(8, 0, 0);
    run_frame(5, 40, 0);
    run_frame(4, 0, 1);
    run_frame(1, 0, 0);
    run_frame(BS + 3, 0, 0);
    run_frame(6, 25, 2);
    for (int f = 0; f < 3; f++) run_frame(int'($urandom_range(1, BS)), int'($urandom_range(0, 50)), 2);

    // Reset in the middle of the forward sweep.
    rd_mode = 0;
    wq.delete();
    rq.delete();
    send_beats(6, 0);
    for (int t = 0; t < 500 && rq.size() < 2; t++) @(posedge aclk);
    #3;
    areset = 1;
    #1;
    chk("midrst_ctrl", {24'd0, s_ready, bm_valid, rd_valid, rd_dir, rd_first, rd_last, busy, err_overflow}, 0);
    chk("midrst_addr", {bm_addr, bm_rd_addr, frame_len}, 0);
    chk("midrst_items", {bm_sys_item, bm_parity_item}, 0);
    @(posedge aclk);
    #1;
    areset = 0;
    chk("midrst_busy", 32'(busy), 0);
    run_frame(3, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
